// File: rtl/temporal_encoder_pkg.sv
// Shared constants for the temporal encoder: hypervector width, default N-gram size
// and the ceil-log2 helper used to size the fill counter.
package temporal_encoder_pkg;

  localparam int unsigned HV_DIMENSION = 32;
  localparam int unsigned NGRAM_SIZE   = 3;

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/temporal_encoder_hv_rotate.sv
// Hypervector permutation: rotate left by one bit, MSB wraps into bit 0.
module hv_rotate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rot_c
);

  assign rot_c = {din[WIDTH-2:0], din[WIDTH-1]};

endmodule

// File: rtl/temporal_encoder.sv
// Sliding N-gram binder: XORs the newest spatial HV with progressively rotated
// older HVs and streams one result per accepted input once the window is full.
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int unsigned ngram_size = NGRAM_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout
);

  localparam int unsigned D      = HV_DIMENSION;
  localparam int unsigned HIST_N = ngram_size - 1;
  localparam int unsigned FILL_W = ceil_log2(ngram_size + 1);

  logic [D-1:0]      hist_q   [HIST_N];
  logic [D-1:0]      hist_d   [HIST_N];
  logic [D-1:0]      hist_rot [HIST_N];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [D-1:0]      hvout_q, hvout_d;
  logic              hvout_valid_q, hvout_valid_d;
  logic [D-1:0]      ngram;
  logic              hvin_fire, hvout_fire;

  for (genvar k = 0; k < HIST_N; k++) begin : g_rot
    hv_rotate #(.WIDTH(D)) u_rot (
      .din   (hist_q[k]),
      .rot_c (hist_rot[k])
    );
  end

  always_comb begin
    hist_d        = hist_q;
    fill_d        = fill_q;
    hvout_d       = hvout_q;
    hvout_valid_d = hvout_valid_q;

    hvin_ready = !hvout_valid_q || hvout_ready;
    hvin_fire  = hvin_valid && hvin_ready;
    hvout_fire = hvout_valid_q && hvout_ready;

    ngram = hvin;
    for (int k = 0; k < int'(HIST_N); k++) begin
      ngram = ngram ^ hist_rot[k];
    end

    // clear wins over both handshakes; a coincident input is dropped
    if (clear) begin
      for (int k = 0; k < int'(HIST_N); k++) begin
        hist_d[k] = '0;
      end
      fill_d        = '0;
      hvout_valid_d = 1'b0;
    end else begin
      if (hvout_fire) begin
        hvout_valid_d = 1'b0;
      end
      if (hvin_fire) begin
        hist_d[0] = hvin;
        for (int k = 1; k < int'(HIST_N); k++) begin
          hist_d[k] = hist_rot[k-1];
        end
        if (fill_q != FILL_W'(ngram_size)) begin
          fill_d = fill_q + FILL_W'(1);
        end
        if ((32'(fill_q) + 32'd1) >= ngram_size) begin
          hvout_d       = ngram;
          hvout_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(HIST_N); k++) begin
        hist_q[k] <= '0;
      end
      fill_q        <= '0;
      hvout_q       <= '0;
      hvout_valid_q <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      hvout_q       <= hvout_d;
      hvout_valid_q <= hvout_valid_d;
    end
  end

  assign hvout       = hvout_q;
  assign hvout_valid = hvout_valid_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed-vector bench for temporal_encoder with D=32, N=3.
module tb_temporal_encoder;
  import temporal_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        hvin_valid;
  logic        hvin_ready;
  logic [31:0] hvin;
  logic        hvout_valid;
  logic        hvout_ready;
  logic [31:0] hvout;

  int vectors  = 0;
  int miscomps = 0;

  temporal_encoder #(.ngram_size(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .hvin_valid  (hvin_valid),
    .hvin_ready  (hvin_ready),
    .hvin        (hvin),
    .hvout_valid (hvout_valid),
    .hvout_ready (hvout_ready),
    .hvout       (hvout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscomps++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // present one input across a single edge, then sample 1ns after it
  task automatic send(input logic [31:0] x);
    @(negedge clk);
    hvin       = x;
    hvin_valid = 1'b1;
    @(posedge clk);
    #1;
    hvin_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    clear       = 1'b0;
    hvin_valid  = 1'b0;
    hvin        = '0;
    hvout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(hvin_ready), 32'd1);
    rst = 1'b0;
    check("rst_valid", 32'(hvout_valid), 32'd0);
    check("rst_hvout", hvout, 32'h0);

    // fill with one-hot vectors
    send(32'h1);
    check("fill1_valid", 32'(hvout_valid), 32'd0);
    send(32'h1);
    check("fill2_valid", 32'(hvout_valid), 32'd0);
    send(32'h1);
    check("fill3_valid", 32'(hvout_valid), 32'd1);
    check("fill3_hvout", hvout, 32'h7);

    // sliding window
    send(32'h0);
    check("slide_valid", 32'(hvout_valid), 32'd1);
    check("slide_hvout", hvout, 32'h6);

    // back-pressure
    @(negedge clk);
    hvout_ready = 1'b0;
    hvin        = 32'h8;
    hvin_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(hvin_ready), 32'd0);
      check("bp_hvout", hvout, 32'h6);
    end
    hvout_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(hvin_ready), 32'd1);
    @(posedge clk);
    #1;
    hvin_valid = 1'b0;
    check("bp_both_valid", 32'(hvout_valid), 32'd1);
    check("bp_both_hvout", hvout, 32'hC);
    @(posedge clk);
    #1;
    check("drain_valid", 32'(hvout_valid), 32'd0);

    // wrap-around through the MSB
    send(32'h8000_0000);
    check("wrap1_hvout", hvout, 32'h8000_0010);
    send(32'h0);
    check("wrap2_hvout", hvout, 32'h0000_0021);
    send(32'h0);
    check("wrap3_hvout", hvout, 32'h0000_0002);
    check("wrap3_valid", 32'(hvout_valid), 32'd1);

    // clear while an output is pending
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_pending_valid", 32'(hvout_valid), 32'd0);

    // clear mid-window with a coincident input
    send(32'h1);
    send(32'h1);
    check("clr_pre_valid", 32'(hvout_valid), 32'd0);
    @(negedge clk);
    clear      = 1'b1;
    hvin       = 32'h1;
    hvin_valid = 1'b1;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    hvin_valid = 1'b0;
    check("clr_drop_valid", 32'(hvout_valid), 32'd0);
    send(32'h1);
    send(32'h1);
    check("clr_refill2_valid", 32'(hvout_valid), 32'd0);
    send(32'h1);
    check("clr_refill3_valid", 32'(hvout_valid), 32'd1);
    check("clr_refill3_hvout", hvout, 32'h7);

    // async reset between edges with an output pending
    @(negedge clk);
    hvout_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(hvout_valid), 32'd0);
    check("arst_hvout", hvout, 32'h0);
    check("arst_ready", 32'(hvin_ready), 32'd1);
    @(negedge clk);
    rst         = 1'b0;
    hvout_ready = 1'b1;
    send(32'h2);
    send(32'h2);
    check("arst_refill2_valid", 32'(hvout_valid), 32'd0);
    send(32'h2);
    check("arst_refill3_valid", 32'(hvout_valid), 32'd1);
    check("arst_refill3_hvout", hvout, 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
